mult_arbiter: RTL and testbench
===============================

Name: mult_arbiter

Overview:
- Shares one `mult` instance (start/busy handshake, one result port) between two requesters: ch0 = `square` path, ch1 = `root`/`final` path.
- Latches each request's operands and sequences the multiplier's start/busy protocol.
- Returns each product to its owning requester with a one-cycle done pulse.
- Sits between the requesters and the single `mult` instance in the lab3 top level.

Parameters:
- DATA_W, 8, operand width; product width is 2*DATA_W.

Ports:
- clk_i  in  1  clock, all logic on rising edge
- rst_i  in  1  synchronous reset, active-low
- req0_i  in  1  ch0 request level; held high until busy0_o is seen high
- a0_bi  in  DATA_W  ch0 operand A
- b0_bi  in  DATA_W  ch0 operand B
- busy0_o  out  1  ch0 accepted and in flight
- done0_o  out  1  one-cycle pulse, y0_bo valid
- y0_bo  out  2*DATA_W  ch0 product, held until the next ch0 completion
- req1_i, a1_bi, b1_bi, busy1_o, done1_o, y1_bo: same as ch0, for ch1
- mult_start_o  out  1  start pulse to `mult`
- mult_a_bo  out  DATA_W  operand A to `mult`
- mult_b_bo  out  DATA_W  operand B to `mult`
- mult_busy_i  in  1  `mult` busy
- mult_y_bi  in  2*DATA_W  `mult` result, valid when busy falls

Behaviour:
- Reset (rst_i==0 at a clock edge):
  - state=IDLE; last_grant=1, so ch0 wins the first tie.
  - All outputs 0: busy*, done*, y*, mult_start_o, mult_a_bo, mult_b_bo.
- Reset mid-operation:
  - Aborts the transaction; no done pulse is issued.
  - The multiplier may still be running; IDLE does not issue until mult_busy_i==0.
- States: IDLE -> ISSUE -> WAIT_ACK -> WAIT_DONE -> RESP -> IDLE.
- IDLE:
  - Leaves only if mult_busy_i==0 and any req is high.
  - Exactly one request: grant it.
  - Both requests: grant the channel != last_grant (round-robin).
  - On grant: latch operands into mult_a_bo/mult_b_bo; set gnt; set busy<gnt>_o=1; update last_grant.
  - Next state ISSUE.
- ISSUE:
  - mult_start_o=1 for exactly this one cycle.
  - Next state WAIT_ACK.
- WAIT_ACK:
  - Wait for mult_busy_i==1, then go to WAIT_DONE.
  - Operands are held stable throughout.
- WAIT_DONE:
  - On mult_busy_i==0: capture mult_y_bi into y<gnt>_bo.
  - Next state RESP.
- RESP:
  - done<gnt>_o=1 for one cycle; busy<gnt>_o cleared in the same cycle.
  - Next state IDLE.
- Other-channel outputs do not change during a transaction.
- Minimum arbitration overhead: 4 cycles plus multiplier latency. Back-to-back grants are allowed on the cycle after RESP.
- Requests arriving while another channel is busy wait; no request is dropped.
- A req still high after done is treated as a new request.
- Starvation: with both channels requesting continuously, grants alternate 0,1,0,1.
- Operands are sampled only at grant; later changes on a*_bi/b*_bi have no effect on the in-flight product.
- No internal arithmetic: the product is passed through at full 2*DATA_W width, no truncation.

Decomposition:
- Shared package `lab3_pkg`:
  - State encoding localparams: S_IDLE=3'd0, S_ISSUE=1, S_WAIT_ACK=2, S_WAIT_DONE=3, S_RESP=4.
  - DATA_W default.
- Optional sub-module `rr_arb2`: 2-input round-robin grant from req0/req1/last_grant, combinational plus last_grant register.
- Everything else in one module.

Test Plan:
- Reset sequence:
  - Stimulus: rst_i=0 for 2 cycles, then 1; no requests.
  - Required: all outputs 0; mult_start_o never asserted.
- Single ch0 request:
  - Stimulus: req0=1, a0=8'd12, b0=8'd11, behavioural mult with 4-cycle busy.
  - Required: one mult_start_o pulse with operands 12/11; busy0_o high through the transaction; done0_o single pulse; y0_bo=16'd132; y1_bo stays 0.
- Simultaneous requests after reset:
  - Stimulus: req0 (255×255) and req1 (3×7) both high.
  - Required: ch0 served first with y0=16'd65025, then ch1 with y1=16'd21; exactly two start pulses.
- Continuous contention:
  - Stimulus: both reqs held high for 6 completions.
  - Required: grant order 0,1,0,1,0,1; done pulses never overlap.
- Operand change after grant:
  - Stimulus: req1 with a1=5, b1=5; change a1 to 9 during WAIT_DONE.
  - Required: y1=16'd25.
- Reset mid-operation:
  - Stimulus: assert rst_i=0 during WAIT_DONE while mult is still busy; release; req0 (2×2) immediately.
  - Required: no done pulse for the aborted request; the new start is issued only after mult_busy_i falls; y0=16'd4.

Source files
------------

// File: rtl/lab3_pkg.sv
// Shared definitions for the lab3 multiplier arbiter: FSM encoding and default width.
package lab3_pkg;

  localparam int DATA_W_DEF = 8;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ISSUE     = 3'd1,
    S_WAIT_ACK  = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_RESP      = 3'd4
  } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin picker: combinational grant plus the last-grant register.
module rr_arb2 (
  input  logic clk_i,
  input  logic rst_i,
  input  logic req0_i,
  input  logic req1_i,
  input  logic upd_i,
  output logic gnt_o
);

  logic r_last;

  // On a tie the channel that did not win last time goes first; reset favours ch0.
  always_comb begin
    gnt_o = req1_i;
    if (req0_i && req1_i) gnt_o = ~r_last;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_last <= 1'b1;
    end else if (upd_i) begin
      r_last <= gnt_o;
    end
  end

endmodule

// File: rtl/mult_arbiter.sv
// Shares a single start/busy multiplier between the square (ch0) and root/final (ch1) paths.
//   state       | meaning
//   S_IDLE      | wait for a request with the multiplier idle, pick a channel, latch operands
//   S_ISSUE     | mult_start_o high for this single cycle
//   S_WAIT_ACK  | wait for the multiplier to raise busy
//   S_WAIT_DONE | wait for busy to fall, capture the product
//   S_RESP      | done pulse to the owner, its busy already cleared
module mult_arbiter
  import lab3_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                req0_i,
  input  logic [DATA_W-1:0]   a0_bi,
  input  logic [DATA_W-1:0]   b0_bi,
  output logic                busy0_o,
  output logic                done0_o,
  output logic [2*DATA_W-1:0] y0_bo,
  input  logic                req1_i,
  input  logic [DATA_W-1:0]   a1_bi,
  input  logic [DATA_W-1:0]   b1_bi,
  output logic                busy1_o,
  output logic                done1_o,
  output logic [2*DATA_W-1:0] y1_bo,
  output logic                mult_start_o,
  output logic [DATA_W-1:0]   mult_a_bo,
  output logic [DATA_W-1:0]   mult_b_bo,
  input  logic                mult_busy_i,
  input  logic [2*DATA_W-1:0] mult_y_bi
);

  state_t              r_state;
  logic                r_gnt;
  logic                r_busy0, r_busy1;
  logic                r_done0, r_done1;
  logic [2*DATA_W-1:0] r_y0, r_y1;
  logic                r_start;
  logic [DATA_W-1:0]   r_a, r_b;

  logic w_gnt;
  logic w_take;

  // After a reset the multiplier may still be finishing an aborted product, so IDLE waits it out.
  assign w_take = (r_state == S_IDLE) && !mult_busy_i && (req0_i || req1_i);

  rr_arb2 u_rr_arb2 (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .req0_i (req0_i),
    .req1_i (req1_i),
    .upd_i  (w_take),
    .gnt_o  (w_gnt)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_state <= S_IDLE;
      r_gnt   <= 1'b0;
      r_busy0 <= 1'b0;
      r_busy1 <= 1'b0;
      r_done0 <= 1'b0;
      r_done1 <= 1'b0;
      r_y0    <= '0;
      r_y1    <= '0;
      r_start <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
    end else begin
      r_start <= 1'b0;
      r_done0 <= 1'b0;
      r_done1 <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_take) begin
            r_gnt   <= w_gnt;
            r_a     <= w_gnt ? a1_bi : a0_bi;
            r_b     <= w_gnt ? b1_bi : b0_bi;
            if (w_gnt) r_busy1 <= 1'b1;
            else       r_busy0 <= 1'b1;
            r_start <= 1'b1;
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_state <= S_WAIT_ACK;
        end
        S_WAIT_ACK: begin
          if (mult_busy_i) r_state <= S_WAIT_DONE;
        end
        S_WAIT_DONE: begin
          if (!mult_busy_i) begin
            if (r_gnt) begin
              r_y1    <= mult_y_bi;
              r_done1 <= 1'b1;
              r_busy1 <= 1'b0;
            end else begin
              r_y0    <= mult_y_bi;
              r_done0 <= 1'b1;
              r_busy0 <= 1'b0;
            end
            r_state <= S_RESP;
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy0_o      = r_busy0;
  assign busy1_o      = r_busy1;
  assign done0_o      = r_done0;
  assign done1_o      = r_done1;
  assign y0_bo        = r_y0;
  assign y1_bo        = r_y1;
  assign mult_start_o = r_start;
  assign mult_a_bo    = r_a;
  assign mult_b_bo    = r_b;

endmodule

// File: tb/tb_mult_arbiter.sv
// Scoreboard bench for mult_arbiter driving a behavioural 4-cycle start/busy multiplier.
module tb_mult_arbiter;

  localparam int W = 8;

  logic           clk_i = 1'b0;
  logic           rst_i = 1'b0;
  logic           req0_i = 1'b0, req1_i = 1'b0;
  logic [W-1:0]   a0_bi = '0, b0_bi = '0, a1_bi = '0, b1_bi = '0;
  logic           busy0_o, done0_o, busy1_o, done1_o;
  logic [2*W-1:0] y0_bo, y1_bo;
  logic           mult_start_o;
  logic [W-1:0]   mult_a_bo, mult_b_bo;
  logic           mult_busy_i;
  logic [2*W-1:0] mult_y_bi;

  mult_arbiter #(.DATA_W(W)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req0_i(req0_i), .a0_bi(a0_bi), .b0_bi(b0_bi),
    .busy0_o(busy0_o), .done0_o(done0_o), .y0_bo(y0_bo),
    .req1_i(req1_i), .a1_bi(a1_bi), .b1_bi(b1_bi),
    .busy1_o(busy1_o), .done1_o(done1_o), .y1_bo(y1_bo),
    .mult_start_o(mult_start_o), .mult_a_bo(mult_a_bo), .mult_b_bo(mult_b_bo),
    .mult_busy_i(mult_busy_i), .mult_y_bi(mult_y_bi)
  );

  always #5 clk_i = ~clk_i;

  // Behavioural multiplier: no reset, busy for 4 cycles, result updated as busy falls.
  logic [W-1:0]   m_a = '0, m_b = '0;
  logic [1:0]     m_cnt = '0;
  logic           m_busy = 1'b0;
  logic [2*W-1:0] m_y = '0;
  assign mult_busy_i = m_busy;
  assign mult_y_bi   = m_y;

  always @(posedge clk_i) begin
    if (mult_start_o && !m_busy) begin
      m_a    <= mult_a_bo;
      m_b    <= mult_b_bo;
      m_busy <= 1'b1;
      m_cnt  <= 2'd3;
    end else if (m_busy) begin
      if (m_cnt == 2'd0) begin
        m_busy <= 1'b0;
        m_y    <= (2*W)'(m_a) * (2*W)'(m_b);
      end else begin
        m_cnt <= m_cnt - 2'd1;
      end
    end
  end

  typedef struct {
    logic           ch;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] y;
  } exp_t;

  exp_t           sb[$];
  int             n_chk = 0;
  int             n_err = 0;
  int             n_start = 0;
  logic [2*W-1:0] mdl_y0 = '0, mdl_y1 = '0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic push(input logic ch, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    e.ch = ch; e.a = a; e.b = b;
    e.y  = (2*W)'(a) * (2*W)'(b);
    sb.push_back(e);
  endtask

  // One clock step; every observation of the DUT happens here, mid-cycle.
  task automatic tick();
    exp_t e;
    @(negedge clk_i);
    if (mult_start_o) begin
      n_start++;
      check("start_mult_idle", 32'(mult_busy_i), 0);
      if (sb.size() == 0) begin
        check("start_unexpected", 1, 0);
      end else begin
        check("op_a", 32'(mult_a_bo), 32'(sb[0].a));
        check("op_b", 32'(mult_b_bo), 32'(sb[0].b));
        check("busy_owner", 32'(sb[0].ch ? busy1_o : busy0_o), 1);
        check("busy_other", 32'(sb[0].ch ? busy0_o : busy1_o), 0);
      end
    end
    if (done0_o || done1_o) begin
      check("done_overlap", 32'(done0_o & done1_o), 0);
      if (sb.size() == 0) begin
        check("done_unexpected", 1, 0);
      end else begin
        e = sb.pop_front();
        check("done_ch", 32'(done1_o), 32'(e.ch));
        check("y_result", 32'(done1_o ? y1_bo : y0_bo), 32'(e.y));
        check("busy_clr", 32'(done1_o ? busy1_o : busy0_o), 0);
        if (e.ch) mdl_y1 = e.y;
        else      mdl_y0 = e.y;
      end
      check("y0_model", 32'(y0_bo), 32'(mdl_y0));
      check("y1_model", 32'(y1_bo), 32'(mdl_y1));
    end
  endtask

  task automatic do_reset();
    rst_i = 1'b0;
    tick();
    tick();
    rst_i = 1'b1;
    sb.delete();
    mdl_y0 = '0;
    mdl_y1 = '0;
  endtask

  task automatic wait_busy(input logic ch, input int max);
    int n = 0;
    while (!(ch ? busy1_o : busy0_o) && n < max) begin
      tick();
      n++;
    end
    if (!(ch ? busy1_o : busy0_o)) check("busy_timeout", 32'(ch), 99);
  endtask

  task automatic wait_mult_busy(input int max);
    int n = 0;
    while (!mult_busy_i && n < max) begin
      tick();
      n++;
    end
    if (!mult_busy_i) check("mult_busy_timeout", 0, 1);
  endtask

  task automatic drain(input int max);
    int n = 0;
    while (sb.size() != 0 && n < max) begin
      tick();
      n++;
    end
    if (sb.size() != 0) begin
      check("drain_timeout", 32'(sb.size()), 0);
      sb.delete();
    end
  endtask

  task automatic single(input logic ch, input logic [W-1:0] a, input logic [W-1:0] b);
    if (ch) begin a1_bi = a; b1_bi = b; req1_i = 1'b1; end
    else    begin a0_bi = a; b0_bi = b; req0_i = 1'b1; end
    push(ch, a, b);
    wait_busy(ch, 20);
    if (ch) req1_i = 1'b0;
    else    req0_i = 1'b0;
  endtask

  logic [W-1:0] ops_a0[3] = '{8'd2, 8'd10, 8'd200};
  logic [W-1:0] ops_b0[3] = '{8'd3, 8'd20, 8'd100};
  logic [W-1:0] ops_a1[3] = '{8'd4, 8'd17, 8'd255};
  logic [W-1:0] ops_b1[3] = '{8'd5, 8'd15, 8'd1};

  initial begin
    int s0;
    int i0, i1, n;

    // Reset sequence
    rst_i = 1'b0;
    tick();
    tick();
    check("rst_ctrl", 32'({busy0_o, busy1_o, done0_o, done1_o, mult_start_o}), 0);
    check("rst_y", 32'({y1_bo, y0_bo}), 0);
    check("rst_ops", 32'({mult_a_bo, mult_b_bo}), 0);
    rst_i = 1'b1;
    repeat (4) tick();
    check("rst_no_start", 32'(n_start), 0);

    // Single ch0 request
    s0 = n_start;
    single(1'b0, 8'd12, 8'd11);
    drain(40);
    check("single_starts", 32'(n_start - s0), 1);
    check("single_y0", 32'(y0_bo), 132);
    check("single_y1", 32'(y1_bo), 0);

    // Simultaneous requests right after reset: ch0 wins the first tie
    do_reset();
    s0 = n_start;
    a0_bi = 8'd255; b0_bi = 8'd255; a1_bi = 8'd3; b1_bi = 8'd7;
    req0_i = 1'b1; req1_i = 1'b1;
    push(1'b0, 8'd255, 8'd255);
    push(1'b1, 8'd3, 8'd7);
    n = 0;
    while ((req0_i || req1_i) && n < 60) begin
      tick();
      n++;
      if (busy0_o) req0_i = 1'b0;
      if (busy1_o) req1_i = 1'b0;
    end
    check("sim_req_timeout", 32'({req0_i, req1_i}), 0);
    req0_i = 1'b0; req1_i = 1'b0;
    drain(40);
    check("sim_starts", 32'(n_start - s0), 2);
    check("sim_y0", 32'(y0_bo), 65025);
    check("sim_y1", 32'(y1_bo), 21);

    // Continuous contention: expected completions strictly alternate
    do_reset();
    for (int k = 0; k < 3; k++) begin
      push(1'b0, ops_a0[k], ops_b0[k]);
      push(1'b1, ops_a1[k], ops_b1[k]);
    end
    a0_bi = ops_a0[0]; b0_bi = ops_b0[0];
    a1_bi = ops_a1[0]; b1_bi = ops_b1[0];
    req0_i = 1'b1; req1_i = 1'b1;
    i0 = 0; i1 = 0; n = 0;
    while ((req0_i || req1_i) && n < 400) begin
      tick();
      n++;
      if (done0_o) begin
        i0++;
        if (i0 < 3) begin a0_bi = ops_a0[i0]; b0_bi = ops_b0[i0]; end
        else req0_i = 1'b0;
      end
      if (done1_o) begin
        i1++;
        if (i1 < 3) begin a1_bi = ops_a1[i1]; b1_bi = ops_b1[i1]; end
        else req1_i = 1'b0;
      end
    end
    req0_i = 1'b0; req1_i = 1'b0;
    check("cont_done_count", 32'(i0 + i1), 6);
    drain(40);

    // Operand change after grant does not affect the product
    do_reset();
    single(1'b1, 8'd5, 8'd5);
    wait_mult_busy(20);
    a1_bi = 8'd9;
    b1_bi = 8'd9;
    drain(40);
    check("opchg_y1", 32'(y1_bo), 25);

    // Reset while the multiplier is mid-product
    do_reset();
    single(1'b0, 8'd7, 8'd7);
    wait_mult_busy(20);
    tick();
    rst_i = 1'b0;
    sb.delete();
    tick();
    rst_i = 1'b1;
    mdl_y0 = '0;
    mdl_y1 = '0;
    check("midrst_busy0", 32'(busy0_o), 0);
    check("midrst_mult_busy", 32'(mult_busy_i), 1);
    a0_bi = 8'd2; b0_bi = 8'd2; req0_i = 1'b1;
    push(1'b0, 8'd2, 8'd2);
    wait_busy(1'b0, 30);
    req0_i = 1'b0;
    drain(40);
    check("midrst_y0", 32'(y0_bo), 4);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
